sram_tdp_sync: RTL and testbench

Parametrised single-clock true-dual-port synchronous SRAM model. It succeeds the fixed 1024x18 dual-port macro model and keeps the same active-low enable, write-enable and per-bit write-mask convention. It adds configurable depth and width, a selectable read-during-write mode, an optional output pipeline stage, read-valid strobes and deterministic same-address collision handling. It sits under the BRAM inference/techmap flow as the behavioural model for generic RAM primitives.

---
 rtl/sram_tdp_pkg.sv | 23 ++
 rtl/sram_tdp_rdpipe.sv | 67 ++++++
 rtl/sram_tdp_sync.sv | 119 +++++++++++
 tb/tb_sram_tdp_sync.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_tdp_pkg.sv
// Shared definitions for the sram_tdp_sync true-dual-port RAM model:
// read-during-write mode encodings and the masked-merge helper.
package sram_tdp_pkg;

  typedef enum int {
    RD_READ_FIRST  = 0,
    RD_WRITE_FIRST = 1,
    RD_NO_CHANGE   = 2
  } rd_mode_e;

  // Widest word mask_merge handles; callers zero-extend and truncate.
  localparam int unsigned MERGE_W = 1024;

  // Active-low mask: 0 takes the new bit, 1 keeps the old bit.
  function automatic logic [MERGE_W-1:0] mask_merge(
    input logic [MERGE_W-1:0] old_w,
    input logic [MERGE_W-1:0] new_w,
    input logic [MERGE_W-1:0] msk
  );
    return (old_w & msk) | (new_w & ~msk);
  endfunction

endpackage

// File: rtl/sram_tdp_rdpipe.sv
// Per-port read output stage: read-during-write selection, NO_CHANGE hold,
// optional second register stage and rvalid generation.
module sram_tdp_rdpipe
  import sram_tdp_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_acc,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_old,
  input  logic [WIDTH-1:0] i_merged,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid
);

  logic             w_ld;
  logic [WIDTH-1:0] w_sel;
  logic             r_v1;
  logic [WIDTH-1:0] r_d1;

  always_comb begin
    w_sel = i_old;
    w_ld  = i_acc;
    if (i_wr) begin
      if (RD_MODE == int'(RD_WRITE_FIRST)) w_sel = i_merged;
      if (RD_MODE == int'(RD_NO_CHANGE))   w_ld  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_ld;
      if (w_ld) r_d1 <= w_sel;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic             r_v2;
      logic [WIDTH-1:0] r_d2;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_d2 <= r_d1;
        end
      end

      assign o_rdata  = r_d2;
      assign o_rvalid = r_v2;
    end else begin : g_noreg
      assign o_rdata  = r_d1;
      assign o_rvalid = r_v1;
    end
  endgenerate

endmodule

// File: rtl/sram_tdp_sync.sv
// Parametrised single-clock true-dual-port synchronous SRAM model.
// Optional macro SRAM_TDP_COLLISION_EN adds the registered 'coll' output.
module sram_tdp_sync
  import sram_tdp_pkg::*;
#(
  parameter int                     DEPTH   = 1024,
  parameter int                     WIDTH   = 18,
  parameter int                     ADDR_W  = $clog2(DEPTH),
  parameter int                     RD_MODE = 0,
  parameter int                     OUT_REG = 0,
  parameter logic [DEPTH*WIDTH-1:0] INIT    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen_a,
  input  logic              wen_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  wmsk_a,
  input  logic [WIDTH-1:0]  wdata_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              cen_b,
  input  logic              wen_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wmsk_b,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b
`ifdef SRAM_TDP_COLLISION_EN
  ,
  output logic              coll
`endif
);

  localparam int              MEM_BITS = DEPTH * WIDTH;
  localparam int              BIT_W    = $clog2(MEM_BITS);
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  // Flat array so contents can be preloaded from INIT at time zero.
  logic [MEM_BITS-1:0] r_mem = INIT;

  function automatic logic [WIDTH-1:0] f_merge(
    input logic [WIDTH-1:0] old_w,
    input logic [WIDTH-1:0] new_w,
    input logic [WIDTH-1:0] msk
  );
    return WIDTH'(mask_merge(MERGE_W'(old_w), MERGE_W'(new_w), MERGE_W'(msk)));
  endfunction

  logic             w_inr_a, w_inr_b;
  logic             w_acc_a, w_acc_b;
  logic             w_we_a, w_we_b, w_same;
  logic [BIT_W-1:0] w_base_a, w_base_b;
  logic [WIDTH-1:0] w_old_a, w_old_b;
  logic [WIDTH-1:0] w_new_a, w_new_b;
  logic [WIDTH-1:0] w_rdm_a, w_rdm_b;

  always_comb begin
    w_inr_a  = {1'b0, addr_a} < LP_DEPTH;
    w_inr_b  = {1'b0, addr_b} < LP_DEPTH;
    w_acc_a  = !rst && !cen_a;
    w_acc_b  = !rst && !cen_b;
    w_we_a   = w_acc_a && !wen_a && w_inr_a;
    w_we_b   = w_acc_b && !wen_b && w_inr_b;
    w_base_a = w_inr_a ? BIT_W'(addr_a) * BIT_W'(WIDTH) : '0;
    w_base_b = w_inr_b ? BIT_W'(addr_b) * BIT_W'(WIDTH) : '0;
    w_old_a  = w_inr_a ? r_mem[w_base_a +: WIDTH] : '0;
    w_old_b  = w_inr_b ? r_mem[w_base_b +: WIDTH] : '0;
    // A merges on top of B's result so A wins on bits both ports unmask.
    w_same   = w_we_b && (addr_a == addr_b);
    w_new_b  = f_merge(w_old_b, wdata_b, wmsk_b);
    w_new_a  = f_merge(w_same ? w_new_b : w_old_a, wdata_a, wmsk_a);
    w_rdm_a  = w_inr_a ? f_merge(w_old_a, wdata_a, wmsk_a) : '0;
    w_rdm_b  = w_inr_b ? w_new_b : '0;
  end

  always_ff @(posedge clk) begin
    if (w_we_b) r_mem[w_base_b +: WIDTH] <= w_new_b;
    if (w_we_a) r_mem[w_base_a +: WIDTH] <= w_new_a;
  end

`ifdef SRAM_TDP_COLLISION_EN
  always_ff @(posedge clk) begin
    if (rst) coll <= 1'b0;
    else     coll <= w_we_a && w_we_b && (addr_a == addr_b) && (|(~wmsk_a & ~wmsk_b));
  end
`endif

  sram_tdp_rdpipe #(
    .WIDTH  (WIDTH),
    .RD_MODE(RD_MODE),
    .OUT_REG(OUT_REG)
  ) u_rdpipe_a (
    .clk     (clk),
    .rst     (rst),
    .i_acc   (w_acc_a),
    .i_wr    (!wen_a),
    .i_old   (w_old_a),
    .i_merged(w_rdm_a),
    .o_rdata (rdata_a),
    .o_rvalid(rvalid_a)
  );

  sram_tdp_rdpipe #(
    .WIDTH  (WIDTH),
    .RD_MODE(RD_MODE),
    .OUT_REG(OUT_REG)
  ) u_rdpipe_b (
    .clk     (clk),
    .rst     (rst),
    .i_acc   (w_acc_b),
    .i_wr    (!wen_b),
    .i_old   (w_old_b),
    .i_merged(w_rdm_b),
    .o_rdata (rdata_b),
    .o_rvalid(rvalid_b)
  );

endmodule

// File: tb/tb_sram_tdp_sync.sv
// Randomised bench for sram_tdp_sync: three configurations share one stimulus
// stream and are checked against an array-based reference model.
module tb_sram_tdp_sync;

  localparam int NDUT = 3;
  localparam int DEP  [NDUT] = '{1024, 1000, 1024};
  localparam int MODE [NDUT] = '{0, 1, 2};
  localparam int OREG [NDUT] = '{0, 1, 0};

  function automatic logic [1024*18-1:0] mk_init();
    logic [1024*18-1:0] v;
    for (int i = 0; i < 1024; i++) v[18*i +: 18] = 18'(i * 32'h1357 + 32'h0AB);
    v[18*3 +: 18] = 18'h22222;
    v[18*5 +: 18] = 18'h2AAAA;
    v[18*7 +: 18] = 18'h3FFFF;
    return v;
  endfunction

  localparam logic [1024*18-1:0] INIT_V = mk_init();

  logic        clk = 1'b0;
  logic        rst;
  logic        cen_a, wen_a, cen_b, wen_b;
  logic [9:0]  addr_a, addr_b;
  logic [17:0] wmsk_a, wdata_a, wmsk_b, wdata_b;

  logic [17:0] d_rdata  [NDUT][2];
  logic        d_rvalid [NDUT][2];
`ifdef SRAM_TDP_COLLISION_EN
  logic        d_coll   [NDUT];
`endif

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    sram_tdp_sync #(
      .DEPTH  (DEP[k]),
      .WIDTH  (18),
      .RD_MODE(MODE[k]),
      .OUT_REG(OREG[k]),
      .INIT   (INIT_V[DEP[k]*18-1:0])
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .cen_a   (cen_a),
      .wen_a   (wen_a),
      .addr_a  (addr_a),
      .wmsk_a  (wmsk_a),
      .wdata_a (wdata_a),
      .rdata_a (d_rdata[k][0]),
      .rvalid_a(d_rvalid[k][0]),
      .cen_b   (cen_b),
      .wen_b   (wen_b),
      .addr_b  (addr_b),
      .wmsk_b  (wmsk_b),
      .wdata_b (wdata_b),
      .rdata_b (d_rdata[k][1]),
      .rvalid_b(d_rvalid[k][1])
`ifdef SRAM_TDP_COLLISION_EN
      ,
      .coll    (d_coll[k])
`endif
    );
  end

  // Reference model state
  logic [17:0] m_mem  [NDUT][1024];
  logic        m_pv   [NDUT][2];
  logic [17:0] m_pd   [NDUT][2];
  logic        m_ov   [NDUT][2];
  logic [17:0] m_od   [NDUT][2];
  logic        m_coll [NDUT];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] merge18(input logic [17:0] old_w, input logic [17:0] new_w,
                                          input logic [17:0] msk);
    return (old_w & msk) | (new_w & ~msk);
  endfunction

  // One clock edge worth of behaviour, evaluated on the currently driven inputs.
  task automatic model_step();
    logic [9:0]  ad [2];
    logic        cn [2];
    logic        wn [2];
    logic [17:0] mk [2];
    logic [17:0] wd [2];
    logic [17:0] old_v, ev_d;
    logic        ev_v, we, inr, wa, wb;
    ad[0] = addr_a; ad[1] = addr_b;
    cn[0] = cen_a;  cn[1] = cen_b;
    wn[0] = wen_a;  wn[1] = wen_b;
    mk[0] = wmsk_a; mk[1] = wmsk_b;
    wd[0] = wdata_a; wd[1] = wdata_b;
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        for (int p = 0; p < 2; p++) begin
          m_pv[k][p] = 1'b0; m_pd[k][p] = '0;
          m_ov[k][p] = 1'b0; m_od[k][p] = '0;
        end
        m_coll[k] = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          we    = !cn[p] && !wn[p];
          inr   = int'(ad[p]) < DEP[k];
          old_v = inr ? m_mem[k][ad[p]] : 18'h0;
          ev_v  = !cn[p] && !(we && MODE[k] == 2);
          if (we && MODE[k] == 1) ev_d = inr ? merge18(old_v, wd[p], mk[p]) : 18'h0;
          else                    ev_d = old_v;
          if (OREG[k] == 0) begin
            m_ov[k][p] = ev_v;
            if (ev_v) m_od[k][p] = ev_d;
          end else begin
            m_ov[k][p] = m_pv[k][p];
            if (m_pv[k][p]) m_od[k][p] = m_pd[k][p];
            m_pv[k][p] = ev_v;
            m_pd[k][p] = ev_d;
          end
        end
        wa = !cn[0] && !wn[0] && (int'(ad[0]) < DEP[k]);
        wb = !cn[1] && !wn[1] && (int'(ad[1]) < DEP[k]);
        m_coll[k] = wa && wb && (ad[0] == ad[1]) && (|(~mk[0] & ~mk[1]));
        if (wb) m_mem[k][ad[1]] = merge18(m_mem[k][ad[1]], wd[1], mk[1]);
        if (wa) m_mem[k][ad[0]] = merge18(m_mem[k][ad[0]], wd[0], mk[0]);
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NDUT; k++) begin
      for (int p = 0; p < 2; p++) begin
        check_val($sformatf("d%0d_rdata_%s", k, (p == 0) ? "a" : "b"),
                  32'(d_rdata[k][p]), 32'(m_od[k][p]));
        check_val($sformatf("d%0d_rvalid_%s", k, (p == 0) ? "a" : "b"),
                  32'(d_rvalid[k][p]), 32'(m_ov[k][p]));
      end
`ifdef SRAM_TDP_COLLISION_EN
      check_val($sformatf("d%0d_coll", k), 32'(d_coll[k]), 32'(m_coll[k]));
`endif
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_idle();
    rst = 1'b0;
    cen_a = 1'b1; wen_a = 1'b1; addr_a = '0; wmsk_a = '1; wdata_a = '0;
    cen_b = 1'b1; wen_b = 1'b1; addr_b = '0; wmsk_b = '1; wdata_b = '0;
  endtask

  task automatic acc_a(input logic we, input logic [9:0] a, input logic [17:0] d,
                       input logic [17:0] m);
    cen_a = 1'b0; wen_a = !we; addr_a = a; wdata_a = d; wmsk_a = m;
  endtask

  task automatic acc_b(input logic we, input logic [9:0] a, input logic [17:0] d,
                       input logic [17:0] m);
    cen_b = 1'b0; wen_b = !we; addr_b = a; wdata_b = d; wmsk_b = m;
  endtask

  function automatic logic [9:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)      return 10'($urandom_range(0, 15));
    else if (r < 9) return 10'($urandom_range(0, 999));
    else            return 10'($urandom_range(1000, 1023));
  endfunction

  function automatic logic [17:0] rand_mask();
    case ($urandom_range(0, 2))
      0:       return 18'h0;
      1:       return 18'h3FFFF;
      default: return 18'($urandom);
    endcase
  endfunction

  initial begin
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < 1024; i++) m_mem[k][i] = INIT_V[18*i +: 18];
    for (int k = 0; k < NDUT; k++) begin
      for (int p = 0; p < 2; p++) begin
        m_pv[k][p] = 1'b0; m_pd[k][p] = '0; m_ov[k][p] = 1'b0; m_od[k][p] = '0;
      end
      m_coll[k] = 1'b0;
    end

    set_idle();
    rst = 1'b1;
    @(negedge clk);
    cycle();
    cycle();

    // INIT read and output latency
    set_idle(); acc_a(1'b0, 10'd5, 18'h0, 18'h3FFFF); cycle();
    check_val("rd5_lat1_data", 32'(d_rdata[0][0]), 32'h2AAAA);
    check_val("rd5_lat1_valid", 32'(d_rvalid[0][0]), 32'h1);
    check_val("rd5_lat2_early", 32'(d_rvalid[1][0]), 32'h0);
    set_idle(); cycle();
    check_val("rd5_lat2_data", 32'(d_rdata[1][0]), 32'h2AAAA);
    check_val("rd5_lat2_valid", 32'(d_rvalid[1][0]), 32'h1);

    // Masked write, read-during-write per mode
    set_idle(); acc_a(1'b1, 10'd7, 18'h00000, 18'h3FF00); cycle();
    check_val("wr7_read_first", 32'(d_rdata[0][0]), 32'h3FFFF);
    check_val("wr7_no_change_data", 32'(d_rdata[2][0]), 32'h2AAAA);
    check_val("wr7_no_change_valid", 32'(d_rvalid[2][0]), 32'h0);
    set_idle(); cycle();
    check_val("wr7_write_first", 32'(d_rdata[1][0]), 32'h3FF00);
    set_idle(); acc_a(1'b0, 10'd7, 18'h0, 18'h3FFFF); cycle();
    check_val("rd7_after_wr", 32'(d_rdata[0][0]), 32'h3FF00);

    // Dual write to one address: full masks then disjoint masks
    set_idle(); acc_a(1'b1, 10'd9, 18'h12345, 18'h0); acc_b(1'b1, 10'd9, 18'h0ABCD, 18'h0); cycle();
`ifdef SRAM_TDP_COLLISION_EN
    check_val("coll_full", 32'(d_coll[0]), 32'h1);
`endif
    set_idle(); acc_a(1'b0, 10'd9, 18'h0, 18'h3FFFF); cycle();
    check_val("rd9_a_wins", 32'(d_rdata[0][0]), 32'h12345);
    set_idle(); acc_a(1'b1, 10'd9, 18'h12345, 18'h3FE00); acc_b(1'b1, 10'd9, 18'h0ABCD, 18'h001FF); cycle();
`ifdef SRAM_TDP_COLLISION_EN
    check_val("coll_disjoint", 32'(d_coll[0]), 32'h0);
`endif
    set_idle(); acc_a(1'b0, 10'd9, 18'h0, 18'h3FFFF); cycle();
    check_val("rd9_halves", 32'(d_rdata[0][0]), 32'h0AB45);

    // Cross-port write/read on one address
    set_idle(); acc_a(1'b1, 10'd3, 18'h11111, 18'h0); acc_b(1'b0, 10'd3, 18'h0, 18'h3FFFF); cycle();
    check_val("xport_old", 32'(d_rdata[0][1]), 32'h22222);
    set_idle(); acc_b(1'b0, 10'd3, 18'h0, 18'h3FFFF); cycle();
    check_val("xport_new", 32'(d_rdata[0][1]), 32'h11111);

    // Reset flushes a full output pipeline
    set_idle(); acc_a(1'b0, 10'd5, 18'h0, 18'h3FFFF); cycle();
    set_idle(); acc_a(1'b0, 10'd7, 18'h0, 18'h3FFFF); cycle();
    set_idle(); acc_a(1'b0, 10'd9, 18'h0, 18'h3FFFF); cycle();
    set_idle(); rst = 1'b1; cycle();
    check_val("rst_flush_valid", 32'(d_rvalid[1][0]), 32'h0);
    check_val("rst_flush_data", 32'(d_rdata[1][0]), 32'h0);
    set_idle(); cycle();
    check_val("rst_no_stale", 32'(d_rvalid[1][0]), 32'h0);

    // Out-of-range access on the 1000-word instance
    set_idle(); acc_a(1'b1, 10'd1010, 18'h3FFFF, 18'h0); cycle();
    set_idle(); acc_a(1'b0, 10'd1010, 18'h0, 18'h3FFFF); cycle();
    set_idle(); cycle();
    check_val("oob_data", 32'(d_rdata[1][0]), 32'h0);
    check_val("oob_valid", 32'(d_rvalid[1][0]), 32'h1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 49) == 0);
      cen_a   = ($urandom_range(0, 3) == 0);
      wen_a   = 1'($urandom_range(0, 1));
      addr_a  = rand_addr();
      wmsk_a  = rand_mask();
      wdata_a = 18'($urandom);
      cen_b   = ($urandom_range(0, 3) == 0);
      wen_b   = 1'($urandom_range(0, 1));
      addr_b  = rand_addr();
      wmsk_b  = rand_mask();
      wdata_b = 18'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
